// File: rtl/mvm_uart_tx.sv
// mvm_uart_tx: serialises one NUM_WORDS-word result vector per valid/ready
// handshake onto the UART tx pin. Each word goes out as one frame, lowest word
// first. A frame is one start bit (0), the data bits LSB first, and then stop
// bits (1). There is no gap between frames.
// Optional build macro UART_TX_PARITY_EN: the first post-data bit carries even
// parity of the data word in place of the first stop bit.
module mvm_uart_tx #(
  parameter int unsigned CLOCKS_PER_PULSE = 33,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned PACKET_SIZE_TX   = 13,
  parameter int unsigned NUM_WORDS        = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_WORDS*BITS_PER_WORD-1:0] s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               tx,
  output logic                               busy
);

  localparam int unsigned VecW  = NUM_WORDS * BITS_PER_WORD;
  localparam int unsigned ClkW  = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int unsigned BitW  = (PACKET_SIZE_TX > 1) ? $clog2(PACKET_SIZE_TX) : 1;
  localparam int unsigned WordW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [ClkW-1:0]  ClkLast  = ClkW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(PACKET_SIZE_TX - 1);
  localparam logic [BitW-1:0]  BitData  = BitW'(BITS_PER_WORD);
  localparam logic [WordW-1:0] WordLast = WordW'(NUM_WORDS - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [VecW-1:0]    buf_q, buf_d;
  logic [WordW-1:0]   word_q, word_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [ClkW-1:0]    clk_q, clk_d;
  logic               tx_q, tx_d;

  logic [BITS_PER_WORD-1:0] cur_word;
  logic [BITS_PER_WORD-1:0] data_shift;

  // The word being sent is always in the low bits of the buffer.
  assign cur_word   = buf_q[BITS_PER_WORD-1:0];
  // The next data bit index is bit_q+1, which is data bit bit_q of the word.
  assign data_shift = cur_word >> bit_q;

  // Next-state logic. tx_d holds the level of the bit that starts on the next edge.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    word_d  = word_q;
    bit_d   = bit_q;
    clk_d   = clk_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (s_valid) begin
          buf_d   = s_data;
          word_d  = '0;
          bit_d   = '0;
          clk_d   = '0;
          tx_d    = 1'b0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (clk_q == ClkLast) begin
          clk_d = '0;
          if (bit_q == BitLast) begin
            bit_d = '0;
            if (word_q == WordLast) begin
              word_d  = '0;
              tx_d    = 1'b1;
              state_d = StIdle;
            end else begin
              word_d = word_q + 1'b1;
              buf_d  = buf_q >> BITS_PER_WORD;
              tx_d   = 1'b0;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            if (bit_q < BitData) begin
              tx_d = data_shift[0];
`ifdef UART_TX_PARITY_EN
            end else if (bit_q == BitData) begin
              tx_d = ^cur_word;
`endif
            end else begin
              tx_d = 1'b1;
            end
          end
        end else begin
          clk_d = clk_q + 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers. Reset aborts any frame and forces the line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      clk_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      clk_q   <= clk_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign s_ready = (state_q == StIdle);
  assign busy    = (state_q == StSend);

endmodule
